// File: rtl/wma_decim_fifo.sv
// wma_decim_fifo: drops the filter pipeline-fill samples, averages each group of
// DEC samples (integrate-and-dump), and buffers the averages in a small FIFO
// with a valid/ready output.
module wma_decim_fifo #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEC   = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FILL  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [N-1:0]             y_in,
    output logic [N-1:0]             m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int unsigned LOG2DEC = $clog2(DEC);
    localparam int unsigned AW      = N + LOG2DEC;
    localparam int unsigned PAW     = $clog2(DEPTH);
    localparam int unsigned PW      = PAW + 1;
    localparam int unsigned FW      = $clog2(FILL + 1);
    localparam int unsigned CW      = LOG2DEC;

    typedef enum logic {
        S_FILL = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    mem_q [DEPTH];

    logic [AW-1:0]   sum;
    logic [N-1:0]    res;
    logic            res_push;
    logic            wr_en;
    logic            pop;
    logic            full;
    logic            empty;

    // FIFO status and head; full when pointer MSBs differ and the rest match
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[PAW] != rd_q[PAW]) && (wr_q[PAW-1:0] == rd_q[PAW-1:0]);
        m_valid = !empty;
        m_data  = empty ? '0 : mem_q[rd_q[PAW-1:0]];
        level   = wr_q - rd_q;
        ovf     = ovf_q;
    end

    // Next state: fill/accumulate sequencing, pointer updates, overflow flag
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        ovf_d    = ovf_q;
        res_push = 1'b0;
        wr_en    = 1'b0;
        sum      = acc_q + AW'(y_in);
        res      = N'(sum >> LOG2DEC);
        pop      = m_valid && m_ready;

        if (clr) begin
            state_d = S_FILL;
            fill_d  = '0;
            cnt_d   = '0;
            acc_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
        end else begin
            if (en) begin
                case (state_q)
                    S_FILL: begin
                        if (fill_q == FW'(FILL - 1)) begin
                            state_d = S_ACC;
                            fill_d  = '0;
                            cnt_d   = '0;
                            acc_d   = '0;
                        end else begin
                            fill_d = fill_q + FW'(1);
                        end
                    end
                    S_ACC: begin
                        if (cnt_q == CW'(DEC - 1)) begin
                            res_push = 1'b1;
                            acc_d    = '0;
                            cnt_d    = '0;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: state_d = S_FILL;
                endcase
            end

            if (pop) begin
                rd_d = rd_q + PW'(1);
            end

            // A pop in the same cycle frees the slot the push needs
            if (res_push) begin
                if (!full || pop) begin
                    wr_en = 1'b1;
                    wr_d  = wr_q + PW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            fill_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; cleared on reset so the head is never X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_q[PAW-1:0]] <= res;
        end
    end

endmodule

// File: tb/tb_wma_decim_fifo.sv
// tb_wma_decim_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based behavioural model, with literal spot checks.
module tb_wma_decim_fifo;

    localparam int N     = 4;
    localparam int DEC   = 4;
    localparam int DEPTH = 4;
    localparam int FILL  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         en;
    logic [N-1:0] y_in;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [2:0]   level;
    logic         ovf;

    int compared   = 0;
    int mismatched = 0;

    // behavioural model state
    int dropped;
    int samples[$];
    int q[$];
    bit movf;

    wma_decim_fifo #(.N(N), .DEC(DEC), .DEPTH(DEPTH), .FILL(FILL)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .y_in(y_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        dropped = 0;
        samples.delete();
        q.delete();
        movf = 1'b0;
    endtask

    // One clock edge of the model given the inputs presented before it
    task automatic model_step(input bit c, input bit e, input int y, input bit r);
        bit full;
        bit pop;
        bit push;
        int res;
        int s;
        push = 1'b0;
        res  = 0;
        if (c) begin
            model_reset();
            return;
        end
        full = (q.size() == DEPTH);
        pop  = (q.size() > 0) && r;
        if (e) begin
            if (dropped < FILL) begin
                dropped++;
            end else begin
                samples.push_back(y);
                if (samples.size() == DEC) begin
                    s = 0;
                    foreach (samples[i]) s += samples[i];
                    res = s / DEC;
                    samples.delete();
                    push = 1'b1;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (!full || pop) q.push_back(res);
            else movf = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("m_valid", int'(m_valid), (q.size() > 0) ? 1 : 0);
        chk("m_data", int'(m_data), (q.size() > 0) ? q[0] : 0);
        chk("level", int'(level), q.size());
        chk("ovf", int'(ovf), int'(movf));
    endtask

    // Entered and left at a falling edge: check, drive, advance model, clock
    task automatic cycle(input bit c, input bit e, input int y, input bit r);
        compare_all();
        clr     = c;
        en      = e;
        y_in    = N'(y);
        m_ready = r;
        model_step(c, e, y, r);
        @(negedge clk);
    endtask

    task automatic feed(input int v, input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, v, r);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; y_in = '0; m_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", int'(m_valid), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_data", int'(m_data), 0);
        rst = 1'b0;

        // 1: constant 8, fill dropped, one-cycle valid pulses of 8
        feed(8, 3, 1'b1);
        feed(8, 3, 1'b1);
        chk("t1_no_early", int'(m_valid), 0);
        feed(8, 1, 1'b1);
        chk("t1_valid", int'(m_valid), 1);
        chk("t1_data", int'(m_data), 8);
        feed(8, 1, 1'b1);
        chk("t1_pulse", int'(m_valid), 0);
        feed(8, 3, 1'b1);
        chk("t1_data2", int'(m_data), 8);

        // 2: floor averaging and full-scale input
        cycle(1'b0, 1'b1, 1, 1'b1);
        cycle(1'b0, 1'b1, 2, 1'b1);
        cycle(1'b0, 1'b1, 3, 1'b1);
        cycle(1'b0, 1'b1, 5, 1'b1);
        chk("t2_floor", int'(m_data), 2);
        feed(15, 4, 1'b1);
        chk("t2_max", int'(m_data), 15);
        cycle(1'b0, 1'b0, 0, 1'b1);

        // 3: back-pressure, overflow, in-order drain
        for (int v = 1; v <= 5; v++) feed(v, 4, 1'b0);
        chk("t3_level", int'(level), 4);
        chk("t3_ovf", int'(ovf), 1);
        for (int v = 1; v <= 4; v++) begin
            chk("t3_drain", int'(m_data), v);
            cycle(1'b0, 1'b0, 0, 1'b1);
        end
        chk("t3_empty_valid", int'(m_valid), 0);
        chk("t3_empty_data", int'(m_data), 0);

        // 4: clr, then push and pop together while full
        cycle(1'b1, 1'b1, 9, 1'b0);
        chk("t4_clr_ovf", int'(ovf), 0);
        feed(0, 3, 1'b0);
        for (int v = 6; v <= 9; v++) feed(v, 4, 1'b0);
        feed(10, 3, 1'b0);
        cycle(1'b0, 1'b1, 10, 1'b1);
        chk("t4_level", int'(level), 4);
        chk("t4_ovf", int'(ovf), 0);
        for (int v = 7; v <= 10; v++) begin
            chk("t4_order", int'(m_data), v);
            cycle(1'b0, 1'b0, 0, 1'b1);
        end

        // 5: en gaps freeze accumulation
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 4, 1'b0);
            if (i < 3) cycle(1'b0, 1'b0, 13, 1'b0);
        end
        chk("t5_valid", int'(m_valid), 1);
        chk("t5_data", int'(m_data), 4);
        cycle(1'b0, 1'b0, 0, 1'b1);

        // 6a: async reset with partial acc and two entries
        feed(3, 8, 1'b0);
        feed(5, 2, 1'b0);
        chk("t6_level_pre", int'(level), 2);
        async_reset();
        feed(12, 6, 1'b1);
        chk("t6_refill", int'(m_valid), 0);
        feed(12, 1, 1'b1);
        chk("t6_result", int'(m_data), 12);
        feed(12, 3, 1'b1);

        // 6b: same via clr
        feed(3, 8, 1'b0);
        feed(5, 2, 1'b0);
        cycle(1'b1, 1'b1, 7, 1'b0);
        chk("t6_clr_level", int'(level), 0);
        chk("t6_clr_valid", int'(m_valid), 0);
        feed(6, 6, 1'b1);
        chk("t6_clr_refill", int'(m_valid), 0);
        feed(6, 1, 1'b1);
        chk("t6_clr_result", int'(m_data), 6);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) async_reset();
            cycle($urandom_range(0, 99) == 0, ($urandom % 4) != 0,
                  int'($urandom_range(0, 15)), ($urandom % 3) == 0);
        end
        compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
